// File: rtl/phys_free_list.sv
// Physical-register free list for rename.
// Circular list of free phys regs with a speculative head (alloc_ptr), a committed
// head (commit_ptr) and a tail fed by retiring uops' old phys regs. A flush rewinds
// the speculative head to the committed head in one cycle.
// Optional feature macro: FREE_LIST_RRAT_EN adds a retirement RAT with a read port.
module phys_free_list #(
  parameter int ARCHFILE_SIZE = 32,
  parameter int PHYSFILE_SIZE = 256,
  localparam int AW = $clog2(ARCHFILE_SIZE),
  localparam int PW = $clog2(PHYSFILE_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req,
  output logic [PW-1:0] alloc_phys,
  output logic          free_empty,
  output logic [PW:0]   free_count,
  input  logic          retire_uop,
  input  logic [AW-1:0] retire_dest_arch,
  input  logic [PW-1:0] retire_dest_phys,
  input  logic [PW-1:0] retire_dest_oldphys,
`ifdef FREE_LIST_RRAT_EN
  input  logic          except,
  input  logic [AW-1:0] rrat_rd_arch,
  output logic [PW-1:0] rrat_rd_phys
`else
  input  logic          except
`endif
);

  logic [PW-1:0] mem [PHYSFILE_SIZE];
  logic [PW:0]   alloc_ptr, commit_ptr, tail_ptr;
  logic [PW:0]   commit_ptr_next, alloc_ptr_next;
  logic          alloc_fire;

  // Emptiness is judged on current state only: a same-cycle retire is not bypassed.
  assign free_count      = tail_ptr - alloc_ptr;
  assign free_empty      = (free_count == '0);
  assign alloc_phys      = mem[alloc_ptr[PW-1:0]];
  assign alloc_fire      = alloc_req && !free_empty && !except;
  assign commit_ptr_next = commit_ptr + (PW+1)'(retire_uop);
  assign alloc_ptr_next  = except ? commit_ptr_next : alloc_ptr + (PW+1)'(alloc_fire);

  // Pointer update; a flush discards every allocation not yet retired.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr  <= '0;
      commit_ptr <= '0;
      tail_ptr   <= (PW+1)'(PHYSFILE_SIZE - ARCHFILE_SIZE);
    end else begin
      alloc_ptr  <= alloc_ptr_next;
      commit_ptr <= commit_ptr_next;
      if (retire_uop) tail_ptr <= tail_ptr + 1'b1;
    end
  end

  // List storage: reset fills the non-architectural regs, retires push old phys regs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHYSFILE_SIZE; i++)
        mem[i] <= (i < PHYSFILE_SIZE - ARCHFILE_SIZE) ? PW'(ARCHFILE_SIZE + i) : '0;
    end else if (retire_uop) begin
      mem[tail_ptr[PW-1:0]] <= retire_dest_oldphys;
    end
  end

`ifdef FREE_LIST_RRAT_EN
  logic [PW-1:0] rrat [ARCHFILE_SIZE];

  assign rrat_rd_phys = rrat[rrat_rd_arch];

  // Retirement RAT: identity at reset, updated with each retiring destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCHFILE_SIZE; i++) rrat[i] <= PW'(i);
    end else if (retire_uop) begin
      rrat[retire_dest_arch] <= retire_dest_phys;
    end
  end
`else
  logic unused_retire_fields;
  assign unused_retire_fields = ^{retire_dest_arch, retire_dest_phys};
`endif

`ifndef SYNTHESIS
  // Simulation checks on the retire stream.
  always @(posedge clk) begin
    if (!rst && retire_uop) begin
      assert (commit_ptr != alloc_ptr)
        else $error("phys_free_list: retire with no outstanding allocation");
`ifdef FREE_LIST_RRAT_EN
      assert (retire_dest_oldphys == rrat[retire_dest_arch])
        else $error("phys_free_list: retire oldphys does not match rrat");
`endif
    end
  end
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list; expected alloc_phys values go through a scoreboard queue.
module tb_phys_free_list;
  localparam int A  = 32;
  localparam int P  = 256;
  localparam int AW = $clog2(A);
  localparam int PW = $clog2(P);

  logic          clk = 0;
  logic          rst, alloc_req, retire_uop, except;
  logic [PW-1:0] alloc_phys, retire_dest_phys, retire_dest_oldphys;
  logic          free_empty;
  logic [PW:0]   free_count;
  logic [AW-1:0] retire_dest_arch;
`ifdef FREE_LIST_RRAT_EN
  logic [AW-1:0] rrat_rd_arch;
  logic [PW-1:0] rrat_rd_phys;
`endif

  int vectors = 0;
  int miscompares = 0;
  int sb[$];

  always #5 clk = ~clk;

  phys_free_list #(.ARCHFILE_SIZE(A), .PHYSFILE_SIZE(P)) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_phys(alloc_phys),
    .free_empty(free_empty), .free_count(free_count), .retire_uop(retire_uop),
    .retire_dest_arch(retire_dest_arch), .retire_dest_phys(retire_dest_phys),
    .retire_dest_oldphys(retire_dest_oldphys),
`ifdef FREE_LIST_RRAT_EN
    .except(except), .rrat_rd_arch(rrat_rd_arch), .rrat_rd_phys(rrat_rd_phys)
`else
    .except(except)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
  endtask

  // Inputs change 1 time unit after the active edge; checks run in that window too.
  task automatic tick();
    @(posedge clk);
    #1;
    alloc_req = 0; retire_uop = 0; except = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  // Present one alloc: the head value seen now is the one rename consumes.
  task automatic do_alloc(input int exp_phys, input string tag);
    int e;
    sb.push_back(exp_phys);
    e = sb.pop_front();
    chk(tag, int'(alloc_phys), e);
    alloc_req = 1;
    tick();
  endtask

  task automatic set_retire(input int arch, input int phys, input int old);
    retire_uop = 1;
    retire_dest_arch = AW'(arch);
    retire_dest_phys = PW'(phys);
    retire_dest_oldphys = PW'(old);
  endtask

  initial begin
    rst = 0; alloc_req = 0; retire_uop = 0; except = 0;
    retire_dest_arch = '0; retire_dest_phys = '0; retire_dest_oldphys = '0;
`ifdef FREE_LIST_RRAT_EN
    rrat_rd_arch = '0;
`endif
    #2;

    // 1: reset state
    do_reset();
    chk("rst_count", int'(free_count), 224);
    chk("rst_phys",  int'(alloc_phys), 32);
    chk("rst_empty", int'(free_empty), 0);

    // 2: three back-to-back allocs
    for (int i = 0; i < 3; i++) do_alloc(32 + i, "t2_alloc");
    chk("t2_head",  int'(alloc_phys), 35);
    chk("t2_count", int'(free_count), 221);

    // reset mid-operation restores the full state
    do_reset();
    chk("midrst_count", int'(free_count), 224);
    chk("midrst_phys",  int'(alloc_phys), 32);

    // 3: alloc, retire oldphys=5, drain until the recycled reg reaches the head
    do_alloc(32, "t3_alloc0");
    chk("t3_count_a", int'(free_count), 223);
    set_retire(5, 32, 5); tick();
    chk("t3_count_r", int'(free_count), 224);
    for (int i = 0; i < 223; i++) do_alloc(33 + i, "t3_drain");
    chk("t3_recycled", int'(alloc_phys), 5);
    chk("t3_count_d",  int'(free_count), 1);
    do_alloc(5, "t3_last");
    chk("t3_empty", int'(free_empty), 1);

    // 4: alloc 4, retire, then flush with a same-cycle alloc_req
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc(32 + i, "t4_alloc");
    set_retire(7, 32, 7); tick();
    chk("t4_count_r", int'(free_count), 221);
    except = 1; alloc_req = 1; tick();
    chk("t4_count_x", int'(free_count), 224);
    chk("t4_phys_x",  int'(alloc_phys), 33);
    // flush in the same cycle as a retire rewinds to the post-retire head
    do_alloc(33, "t4b_alloc");
    do_alloc(34, "t4b_alloc");
    set_retire(8, 33, 8); except = 1; tick();
    chk("t4b_count", int'(free_count), 224);
    chk("t4b_phys",  int'(alloc_phys), 34);

    // 5: drain to empty, refused alloc, retire+alloc while empty
    do_reset();
    for (int i = 0; i < 224; i++) do_alloc(32 + i, "t5_drain");
    chk("t5_empty",   int'(free_empty), 1);
    chk("t5_count0",  int'(free_count), 0);
    alloc_req = 1; tick();
    chk("t5_ign_cnt", int'(free_count), 0);
    chk("t5_ign_emp", int'(free_empty), 1);
    set_retire(9, 32, 9); alloc_req = 1; tick();
    chk("t5_nempty",  int'(free_empty), 0);
    chk("t5_count1",  int'(free_count), 1);
    chk("t5_phys9",   int'(alloc_phys), 9);

`ifdef FREE_LIST_RRAT_EN
    // 6: retirement RAT update
    do_reset();
    rrat_rd_arch = 3;
    #1;
    chk("t6_rrat_rst", int'(rrat_rd_phys), 3);
    do_alloc(32, "t6_alloc");
    set_retire(3, 32, 3);
    #1;
    chk("t6_nobypass", int'(rrat_rd_phys), 3);
    tick();
    chk("t6_rrat_upd", int'(rrat_rd_phys), 32);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
